systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Start/done sequencing FSM for the 2x2 convolution systolic array: operand feed, pipeline flush, result drain.
// Optional build macro SYSTOLIC_SEQ_AUTO_ACK_EN makes DONE a one-cycle pulse and ignores ack.
//
// state | meaning
// IDLE  | waiting for start, zero operands selected
// FEED  | stepping operand mux 0..FEED_CYCLES-1, PEs accumulate
// FLUSH | one bubble cycle with zero operands so the last products settle
// DRAIN | PEs in pass mode shifting results into the output registers
// DONE  | result held in output registers until acknowledged
module systolic_seq_ctrl #(
    parameter int FEED_CYCLES  = 13,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    output logic [3:0] step,
    output logic       pe_en,
    output logic       pe_mode,
    output logic       mem_en,
    output logic       busy,
    output logic       done
);

    if (FEED_CYCLES < 1 || FEED_CYCLES > 15) begin : g_bad_feed
        $error("systolic_seq_ctrl: FEED_CYCLES=%0d outside 1..15", FEED_CYCLES);
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("systolic_seq_ctrl: DRAIN_CYCLES=%0d outside 1..15", DRAIN_CYCLES);
    end

    localparam logic [3:0] FEED_LAST  = 4'(FEED_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] STEP_ZERO  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = 4'd0;
                if (start) state_nxt = S_FEED;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_FLUSH: begin
                state_nxt = S_DRAIN;
                cnt_nxt   = 4'd0;
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
`ifdef SYSTOLIC_SEQ_AUTO_ACK_EN
                state_nxt = S_IDLE;
`else
                if (ack) state_nxt = S_IDLE;
`endif
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        // abort outranks every other transition, including terminal counts
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    // Moore decode from the state and count flops only
    always_comb begin
        step    = STEP_ZERO;
        pe_en   = 1'b0;
        pe_mode = 1'b0;
        mem_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_FEED: begin
                step  = cnt;
                pe_en = 1'b1;
                busy  = 1'b1;
            end
            S_FLUSH: begin
                pe_en = 1'b1;
                busy  = 1'b1;
            end
            S_DRAIN: begin
                pe_en   = 1'b1;
                pe_mode = 1'b1;
                mem_en  = 1'b1;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: default instance (13/2) and a short instance (4/1), scoreboard of expected
// per-cycle output vectors {step,pe_en,pe_mode,mem_en,busy,done}. Honours SYSTOLIC_SEQ_AUTO_ACK_EN when defined.
module tb_systolic_seq_ctrl;

    localparam logic [8:0] V_IDLE  = {4'hF, 5'b00000};
    localparam logic [8:0] V_FLUSH = {4'hF, 5'b10010};
    localparam logic [8:0] V_DRAIN = {4'hF, 5'b11110};
    localparam logic [8:0] V_DONE  = {4'hF, 5'b00001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, start_a = 1'b0, abort_a = 1'b0, ack_a = 1'b0;
    logic       rst_b = 1'b0, start_b = 1'b0, abort_b = 1'b0, ack_b = 1'b0;
    logic [3:0] step_a, step_b;
    logic       pe_en_a, pe_mode_a, mem_en_a, busy_a, done_a;
    logic       pe_en_b, pe_mode_b, mem_en_b, busy_b, done_b;

    systolic_seq_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .ack(ack_a),
        .step(step_a), .pe_en(pe_en_a), .pe_mode(pe_mode_a), .mem_en(mem_en_a),
        .busy(busy_a), .done(done_a)
    );

    systolic_seq_ctrl #(.FEED_CYCLES(4), .DRAIN_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .ack(ack_b),
        .step(step_b), .pe_en(pe_en_b), .pe_mode(pe_mode_b), .mem_en(mem_en_b),
        .busy(busy_b), .done(done_b)
    );

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] rest_a = V_IDLE;
    logic [8:0] rest_b = V_IDLE;
    logic [8:0] exp_v, obs_v;
    string      tag = "reset";
    int         checks = 0;
    int         failures = 0;

    // Expected vectors for one full job starting the cycle after the start edge
    task automatic push_job(input bit to_b, input int f, input int d);
        logic [8:0] v;
        for (int i = 0; i < f + 1 + d + 1; i++) begin
            if (i < f)           v = {4'(i), 5'b10010};
            else if (i == f)     v = V_FLUSH;
            else if (i <= f + d) v = V_DRAIN;
            else                 v = V_DONE;
            if (to_b) q_b.push_back(v); else q_a.push_back(v);
        end
`ifdef SYSTOLIC_SEQ_AUTO_ACK_EN
        if (to_b) rest_b = V_IDLE; else rest_a = V_IDLE;
`else
        if (to_b) rest_b = V_DONE; else rest_a = V_DONE;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        exp_v = (q_a.size() > 0) ? q_a.pop_front() : rest_a;
        obs_v = {step_a, pe_en_a, pe_mode_a, mem_en_a, busy_a, done_a};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s dut_a observed=%h expected=%h", tag, obs_v, exp_v);
        end
        exp_v = (q_b.size() > 0) ? q_b.pop_front() : rest_b;
        obs_v = {step_b, pe_en_b, pe_mode_b, mem_en_b, busy_b, done_b};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s dut_b observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    initial begin
        // reset both instances, then idle
        rst_a = 1'b1; rst_b = 1'b1;
        cyc();
        rst_a = 1'b0; rst_b = 1'b0;
        tag = "idle";
        repeat (5) cyc();

        // default job, done held until ack
        tag = "job_a";
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        repeat (15) cyc();
        tag = "done_hold";
        repeat (11) cyc();
        tag = "ack";
        ack_a = 1'b1; q_a.delete(); rest_a = V_IDLE;
        cyc();
        ack_a = 1'b0;
        cyc();

        // abort at step 6 with start also high, restart two cycles later
        tag = "pre_abort";
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        repeat (6) cyc();
        tag = "abort";
        abort_a = 1'b1; start_a = 1'b1; q_a.delete(); rest_a = V_IDLE;
        cyc();
        abort_a = 1'b0; start_a = 1'b0;
        cyc();
        tag = "restart";
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        // start during FEED must not disturb step
        tag = "start_in_feed";
        start_a = 1'b1;
        repeat (4) cyc();
        start_a = 1'b0;
        repeat (10) cyc();
        tag = "rst_in_drain";
        rst_a = 1'b1; start_a = 1'b1; q_a.delete(); rest_a = V_IDLE;
        cyc();
        rst_a = 1'b0; start_a = 1'b0;
        repeat (2) cyc();

        // short instance: two back-to-back jobs, ack ignored during FEED
        tag = "job_b1";
        start_b = 1'b1; push_job(1'b1, 4, 1);
        cyc();
        start_b = 1'b0; ack_b = 1'b1;
        repeat (2) cyc();
        ack_b = 1'b0;
        repeat (6) cyc();
        tag = "ack_b";
        ack_b = 1'b1; q_b.delete(); rest_b = V_IDLE;
        cyc();
        ack_b = 1'b0;
        tag = "job_b2";
        start_b = 1'b1; push_job(1'b1, 4, 1);
        cyc();
        start_b = 1'b0;
        repeat (8) cyc();
        ack_b = 1'b1; q_b.delete(); rest_b = V_IDLE;
        cyc();
        ack_b = 1'b0;
        cyc();

`ifdef SYSTOLIC_SEQ_AUTO_ACK_EN
        // ack held high throughout has no effect on the one-cycle done pulse
        tag = "auto_ack";
        ack_a = 1'b1;
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        repeat (20) cyc();
        ack_a = 1'b0;
`else
        // start and ack together in DONE: only ack acts
        tag = "ack_start_done";
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        repeat (17) cyc();
        ack_a = 1'b1; start_a = 1'b1; q_a.delete(); rest_a = V_IDLE;
        cyc();
        ack_a = 1'b0; start_a = 1'b0;
        repeat (3) cyc();
        tag = "abort_in_done";
        start_a = 1'b1; push_job(1'b0, 13, 2);
        cyc();
        start_a = 1'b0;
        repeat (17) cyc();
        abort_a = 1'b1; q_a.delete(); rest_a = V_IDLE;
        cyc();
        abort_a = 1'b0;
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
